// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - tile scheduler walking an M x N output-tile grid through load/compute/store
module tile_sequencer #(
  parameter int TILE_W = 8,
  parameter int KLEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic [TILE_W-1:0]   cmd_m_tiles,
  input  logic [TILE_W-1:0]   cmd_n_tiles,
  input  logic [KLEN_W-1:0]   cmd_k_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [TILE_W-1:0]   tile_m,
  output logic [TILE_W-1:0]   tile_n,
  output logic [2*TILE_W-1:0] tiles_done,
  output logic                load_start,
  output logic [KLEN_W-1:0]   load_k_len,
  input  logic                load_done,
  output logic                comp_start,
  input  logic                comp_done,
  output logic                store_start,
  input  logic                store_done
);

  localparam int TD_W = 2 * TILE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_COMP,
    S_COMP_WAIT,
    S_STORE,
    S_STORE_WAIT,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   m_tiles_q, m_tiles_d;
  logic [TILE_W-1:0]   n_tiles_q, n_tiles_d;
  logic [KLEN_W-1:0]   k_len_q, k_len_d;
  logic [TILE_W-1:0]   tile_m_q, tile_m_d;
  logic [TILE_W-1:0]   tile_n_q, tile_n_d;
  logic [TD_W-1:0]     tiles_done_q, tiles_done_d;
  logic                err_flag_q, err_flag_d;

  logic last_n;
  logic last_m;

  assign last_n = (tile_n_q == n_tiles_q - TILE_W'(1));
  assign last_m = (tile_m_q == m_tiles_q - TILE_W'(1));

  // State register and latched job fields; rst clears everything so no done pulse follows an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      m_tiles_q    <= '0;
      n_tiles_q    <= '0;
      k_len_q      <= '0;
      tile_m_q     <= '0;
      tile_n_q     <= '0;
      tiles_done_q <= '0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_tiles_q    <= m_tiles_d;
      n_tiles_q    <= n_tiles_d;
      k_len_q      <= k_len_d;
      tile_m_q     <= tile_m_d;
      tile_n_q     <= tile_n_d;
      tiles_done_q <= tiles_done_d;
      err_flag_q   <= err_flag_d;
    end
  end

  // Next-state logic: each start state lasts one cycle, each wait state only listens to its own done
  always_comb begin
    state_d      = state_q;
    m_tiles_d    = m_tiles_q;
    n_tiles_d    = n_tiles_q;
    k_len_d      = k_len_q;
    tile_m_d     = tile_m_q;
    tile_n_d     = tile_n_q;
    tiles_done_d = tiles_done_q;
    err_flag_d   = err_flag_q;

    case (state_q)
      S_IDLE: begin
        tile_m_d = '0;
        tile_n_d = '0;
        if (cmd_start) begin
          m_tiles_d    = cmd_m_tiles;
          n_tiles_d    = cmd_n_tiles;
          k_len_d      = cmd_k_len;
          tiles_done_d = '0;
          if ((cmd_m_tiles == '0) || (cmd_n_tiles == '0) || (cmd_k_len == '0)) begin
            err_flag_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:      state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: if (load_done) state_d = S_COMP;
      S_COMP:      state_d = S_COMP_WAIT;
      S_COMP_WAIT: if (comp_done) state_d = S_STORE;
      S_STORE:     state_d = S_STORE_WAIT;
      S_STORE_WAIT: begin
        if (store_done) begin
          tiles_done_d = tiles_done_q + TD_W'(1);
          if (last_n && last_m) begin
            state_d = S_FIN;
          end else if (last_n) begin
            tile_n_d = '0;
            tile_m_d = tile_m_q + TILE_W'(1);
            state_d  = S_LOAD;
          end else begin
            tile_n_d = tile_n_q + TILE_W'(1);
            state_d  = S_LOAD;
          end
        end
      end
      S_FIN: begin
        tile_m_d   = '0;
        tile_n_d   = '0;
        err_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = (state_q == S_FIN) && err_flag_q;
  assign load_start  = (state_q == S_LOAD);
  assign comp_start  = (state_q == S_COMP);
  assign store_start = (state_q == S_STORE);
  assign tile_m      = tile_m_q;
  assign tile_n      = tile_n_q;
  assign tiles_done  = tiles_done_q;
  assign load_k_len  = k_len_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - self-checking bench for tile_sequencer
module tb_tile_sequencer;

  localparam int TW = 8;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start;
  logic [TW-1:0] cmd_m_tiles;
  logic [TW-1:0] cmd_n_tiles;
  logic [KW-1:0] cmd_k_len;
  logic          busy, done, err;
  logic [TW-1:0] tile_m, tile_n;
  logic [2*TW-1:0] tiles_done;
  logic          load_start, comp_start, store_start;
  logic [KW-1:0] load_k_len;
  logic          load_done, comp_done, store_done;

  tile_sequencer #(.TILE_W(TW), .KLEN_W(KW)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles), .cmd_k_len(cmd_k_len),
    .busy(busy), .done(done), .err(err),
    .tile_m(tile_m), .tile_n(tile_n), .tiles_done(tiles_done),
    .load_start(load_start), .load_k_len(load_k_len), .load_done(load_done),
    .comp_start(comp_start), .comp_done(comp_done),
    .store_start(store_start), .store_done(store_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the most recent job, in cycles counted from the cmd_start cycle (cycle 0)
  int r_load_c, r_comp_c, r_store_c, r_done_c, r_busy_cycles;
  int r_last_m, r_last_n;

  typedef struct {
    int m;
    int n;
    int k;
    int lat;
    bit exp_err;
    int exp_tiles;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cmd_start  = 1'b0;
    load_done  = 1'b0;
    comp_done  = 1'b0;
    store_done = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " ctl"}, int'({busy, done, err, load_start, comp_start, store_start}), 0);
    chk({name, " idx"}, int'({tile_m, tile_n}), 0);
    chk({name, " cnt"}, int'(tiles_done), 0);
    chk({name, " klen"}, int'(load_k_len), 0);
  endtask

  // Runs one job. Responders answer lat cycles after each observed start (random 1..4 when rnd).
  // abort_idx >= 0 asserts rst in the COMP_WAIT cycle of that tile instead of finishing.
  task automatic run_job(input string tag, input int m, input int n, input int k, input int lat,
                         input bit rnd, input bit stray, input int abort_idx,
                         input bit exp_err, input int exp_tiles);
    int exp_m[$];
    int exp_n[$];
    int ld, cp, st;
    int nl, nc, ns, nd;
    int tile_bad, k_bad, err_bad;
    int budget;
    bit finished, aborted;
    ld = 0; cp = 0; st = 0;
    nl = 0; nc = 0; ns = 0; nd = 0;
    tile_bad = 0; k_bad = 0; err_bad = 0;
    finished = 0; aborted = 0;
    r_load_c = -1; r_comp_c = -1; r_store_c = -1; r_done_c = -1; r_busy_cycles = 0;
    r_last_m = -1; r_last_n = -1;
    if (!exp_err)
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          exp_m.push_back(i);
          exp_n.push_back(j);
        end
    budget = m * n * 16 + 20;

    cmd_start   = 1'b1;
    cmd_m_tiles = m[TW-1:0];
    cmd_n_tiles = n[TW-1:0];
    cmd_k_len   = k[KW-1:0];

    for (int cyc = 1; cyc <= budget && !finished && !aborted; cyc++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (busy) r_busy_cycles++;
      if (busy && int'(load_k_len) != k) k_bad++;
      if (err && !done) err_bad++;
      if (load_start) begin
        nl++;
        if (r_load_c < 0) r_load_c = cyc;
        if (exp_m.size() == 0 || int'(tile_m) != exp_m[0] || int'(tile_n) != exp_n[0]) tile_bad++;
      end
      if (comp_start) begin
        nc++;
        if (r_comp_c < 0) r_comp_c = cyc;
        if (exp_m.size() == 0 || int'(tile_m) != exp_m[0] || int'(tile_n) != exp_n[0]) tile_bad++;
      end
      if (store_start) begin
        ns++;
        if (r_store_c < 0) r_store_c = cyc;
        r_last_m = int'(tile_m);
        r_last_n = int'(tile_n);
        if (exp_m.size() == 0 || int'(tile_m) != exp_m[0] || int'(tile_n) != exp_n[0]) tile_bad++;
        if (exp_m.size() != 0) begin
          void'(exp_m.pop_front());
          void'(exp_n.pop_front());
        end
      end
      if (done) begin
        nd++;
        r_done_c = cyc;
        finished = 1;
        chk({tag, " err at done"}, int'(err), int'(exp_err));
        chk({tag, " tiles_done at done"}, int'(tiles_done), exp_tiles);
      end
      // responders: count down outstanding work, then register newly observed starts
      if (ld > 0) begin ld--; if (ld == 0) load_done = 1'b1; end
      if (cp > 0) begin cp--; if (cp == 0) comp_done = 1'b1; end
      if (st > 0) begin st--; if (st == 0) store_done = 1'b1; end
      if (load_start)  ld = rnd ? $urandom_range(1, 4) : lat;
      if (comp_start)  cp = rnd ? $urandom_range(1, 4) : lat;
      if (store_start) st = rnd ? $urandom_range(1, 4) : lat;
      if (comp_start && abort_idx == nc - 1 && nc - 1 == ns) begin
        // this cycle is COMP_WAIT of the aborted tile
        @(posedge clk); #1;
        rst = 1'b1;
        aborted = 1;
      end
      if (stray && !aborted) begin
        if (ld > 0 && $urandom_range(0, 3) == 0) comp_done  = 1'b1;
        if (ld > 0 && $urandom_range(0, 3) == 0) store_done = 1'b1;
        if (cp > 0 && $urandom_range(0, 3) == 0) load_done  = 1'b1;
        if (st > 0 && $urandom_range(0, 3) == 0) comp_done  = 1'b1;
        if (busy && !done && $urandom_range(0, 7) == 0) begin
          cmd_start   = 1'b1;
          cmd_m_tiles = TW'($urandom_range(1, 9));
          cmd_n_tiles = TW'($urandom_range(1, 9));
          cmd_k_len   = KW'($urandom_range(1, 999));
        end
      end
    end

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
      check_all_zero({tag, " after rst"});
      nd = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (done || busy) nd++;
      end
      chk({tag, " quiet after rst"}, nd, 0);
      return;
    end

    chk({tag, " finished in budget"}, int'(finished), 1);
    clear_inputs();
    chk({tag, " load count"}, nl, exp_tiles);
    chk({tag, " comp count"}, nc, exp_tiles);
    chk({tag, " store count"}, ns, exp_tiles);
    chk({tag, " done count"}, nd, 1);
    chk({tag, " tile order"}, tile_bad, 0);
    chk({tag, " tiles left"}, exp_m.size(), 0);
    chk({tag, " k_len stable"}, k_bad, 0);
    chk({tag, " stray err"}, err_bad, 0);
    chk({tag, " busy span"}, r_busy_cycles, r_done_c);
    @(posedge clk); #1;
    chk({tag, " idle ctl"}, int'({busy, done, err, load_start, comp_start, store_start}), 0);
    chk({tag, " idle idx"}, int'({tile_m, tile_n}), 0);
    chk({tag, " idle tiles_done held"}, int'(tiles_done), exp_tiles);
  endtask

  vec_t vecs[8];

  initial begin
    int m, n, k;
    vecs[0] = '{m: 2, n: 3, k: 64,    lat: 3, exp_err: 1'b0, exp_tiles: 6};
    vecs[1] = '{m: 1, n: 1, k: 1,     lat: 1, exp_err: 1'b0, exp_tiles: 1};
    vecs[2] = '{m: 3, n: 1, k: 7,     lat: 2, exp_err: 1'b0, exp_tiles: 3};
    vecs[3] = '{m: 1, n: 4, k: 65535, lat: 1, exp_err: 1'b0, exp_tiles: 4};
    vecs[4] = '{m: 0, n: 3, k: 5,     lat: 1, exp_err: 1'b1, exp_tiles: 0};
    vecs[5] = '{m: 4, n: 0, k: 16,    lat: 1, exp_err: 1'b1, exp_tiles: 0};
    vecs[6] = '{m: 2, n: 2, k: 0,     lat: 1, exp_err: 1'b1, exp_tiles: 0};
    vecs[7] = '{m: 3, n: 2, k: 300,   lat: 4, exp_err: 1'b0, exp_tiles: 6};

    rst = 1'b1;
    clear_inputs();
    cmd_m_tiles = '0;
    cmd_n_tiles = '0;
    cmd_k_len   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_job($sformatf("vec%0d", i), vecs[i].m, vecs[i].n, vecs[i].k, vecs[i].lat,
              1'b0, 1'b0, -1, vecs[i].exp_err, vecs[i].exp_tiles);

    // 1x1 job, done returned so the phases are spaced three cycles apart
    run_job("1x1 timing", 1, 1, 9, 2, 1'b0, 1'b0, -1, 1'b0, 1);
    chk("1x1 load_start cycle", r_load_c, 1);
    chk("1x1 comp_start cycle", r_comp_c, 4);
    chk("1x1 store_start cycle", r_store_c, 7);
    chk("1x1 done cycle", r_done_c, 10);

    // rejected command: done/err one cycle after start, no start pulses
    run_job("reject n0", 4, 0, 16, 1, 1'b0, 1'b0, -1, 1'b1, 0);
    chk("reject done cycle", r_done_c, 1);
    chk("reject busy cycles", r_busy_cycles, 1);

    // stray done pulses and extra cmd_start while busy
    run_job("stray 2x3", 2, 3, 64, 3, 1'b0, 1'b1, -1, 1'b0, 6);

    // reset during COMP_WAIT of tile (0,1), then a fresh job
    run_job("abort 2x2", 2, 2, 8, 3, 1'b0, 1'b0, 1, 1'b0, 4);
    run_job("after abort 1x1", 1, 1, 5, 1, 1'b0, 1'b0, -1, 1'b0, 1);

    // randomized jobs against the tile-list model
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      k = $urandom_range(1, 65535);
      run_job($sformatf("rand%0d %0dx%0d", r, m, n), m, n, k, 1, 1'b1, 1'b1, -1, 1'b0, m * n);
    end

    // boundary dimensions at full 8-bit width
    run_job("wide m 255x20", 255, 20, 1, 1, 1'b0, 1'b0, -1, 1'b0, 5100);
    chk("255x20 last tile_m", r_last_m, 254);
    chk("255x20 last tile_n", r_last_n, 19);
    run_job("wide n 2x255", 2, 255, 1, 1, 1'b0, 1'b0, -1, 1'b0, 510);
    chk("2x255 last tile_m", r_last_m, 1);
    chk("2x255 last tile_n", r_last_n, 254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
